// File: rtl/mixer_pkg.sv
// Shared types, width formulas and helpers for the mix sequencer.
// Imported by the sequencer, its divider and the bench.
package mixer_pkg;

  localparam int WIDTH      = 24;
  localparam int N_WAVEGENS = 16;
  localparam int VOL_FRAC   = 8;
  localparam int IDX_W      = $clog2(N_WAVEGENS);
  localparam int CNT_W      = $clog2(N_WAVEGENS + 1);
  localparam int ACC_W      = WIDTH + CNT_W;
  localparam int PW         = ACC_W + 32 + CNT_W;
  localparam int LATENCY    = N_WAVEGENS + PW + 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    MUL,
    DIV,
    OUT
  } state_t;

  function automatic int unsigned popcount(
    input logic [63:0] v
  );
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++)
      c += {31'd0, v[i]};
    return c;
  endfunction

  // Clamp v into the signed range of a w-bit word.
  function automatic logic signed [127:0] saturate(
    input logic signed [127:0] v,
    input int unsigned         w
  );
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (v > hi)
      return hi;
    if (v < lo)
      return lo;
    return v;
  endfunction

endpackage

// File: rtl/mix_sequencer_if.sv
// Sample-tick, sample-buffer and output bundle of the mix sequencer.
// master: tick/config/buffer side; slave: the sequencer.
interface mix_sequencer_if #(
  parameter int WIDTH      = 24,
  parameter int N_WAVEGENS = 16,
  parameter int IDX_W      = $clog2(N_WAVEGENS)
);

  logic                    sample_tick;
  logic [N_WAVEGENS-1:0]   enable;
  logic signed [31:0]      master_volume;
  logic [IDX_W-1:0]        wave_rd_addr;
  logic signed [WIDTH-1:0] wave_rd_data;
  logic signed [WIDTH-1:0] out;
  logic                    out_valid;
  logic                    busy;
  logic                    overrun;

  modport master (
    output sample_tick,
    output enable,
    output master_volume,
    output wave_rd_data,
    input  wave_rd_addr,
    input  out,
    input  out_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  sample_tick,
    input  enable,
    input  master_volume,
    input  wave_rd_data,
    output wave_rd_addr,
    output out,
    output out_valid,
    output busy,
    output overrun
  );

endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, PW cycles.
// Ports: start/dividend/divisor in; done (final step) and quotient out.
module seq_divider #(
  parameter int PW = 66,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [PW-1:0] quotient
);

  localparam int CW = $clog2(PW + 1);

  logic [PW-1:0] quo;
  logic [DW-1:0] rem;
  logic [CW-1:0] cnt;
  logic [DW:0]   sh;
  logic          ge;

  always_comb begin
    sh = {rem, quo[PW-1]};
    ge = (sh >= {1'b0, divisor});
  end

  // done marks the step that writes the last quotient bit
  assign done     = (cnt == CW'(1));
  assign quotient = quo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      cnt <= CW'(PW);
    end else if (cnt != '0) begin
      quo <= {quo[PW-2:0], ge};
      rem <= ge ? DW'(sh - {1'b0, divisor})
                : sh[DW-1:0];
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/mix_sequencer.sv
// Time-multiplexed oscillator mixer: serial fetch, gain, headroom divide.
// Ports: clk, rst, bus (slave: tick/enable/volume/buffer in, out/valid/busy/overrun).
module mix_sequencer #(
  parameter int WIDTH      = 24,
  parameter int N_WAVEGENS = 16,
  parameter int VOL_FRAC   = 8
) (
  input logic           clk,
  input logic           rst,
  mix_sequencer_if.slave bus
);

  import mixer_pkg::*;

  localparam int IDX_W = $clog2(N_WAVEGENS);
  localparam int CNT_W = $clog2(N_WAVEGENS + 1);
  localparam int ACC_W = WIDTH + CNT_W;
  localparam int PW    = ACC_W + 32 + CNT_W;
  localparam int DW    = CNT_W + 1;

  state_t                  state;
  logic [N_WAVEGENS-1:0]   en_q;
  logic signed [31:0]      vol_q;
  logic [CNT_W-1:0]        n_q;
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        addr;
  logic [IDX_W-1:0]        rd_idx;
  logic                    rd_pend;
  logic                    neg_q;
  logic signed [WIDTH-1:0] out_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    ovr_q;

  logic signed [PW-1:0]    prod;
  logic [PW-1:0]           mag;
  logic [DW-1:0]           divisor;
  logic                    div_start;
  logic                    div_done;
  logic [PW-1:0]           quo;
  logic signed [PW-1:0]    q;
  logic signed [WIDTH-1:0] mixed;
  logic signed [ACC_W-1:0] smp;

  assign bus.wave_rd_addr = addr;
  assign bus.out          = out_q;
  assign bus.out_valid    = valid_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = ovr_q;

  // Sample of the slot addressed last cycle, gated by its snapshot bit
  always_comb begin
    smp = '0;
    if (rd_pend && en_q[rd_idx])
      smp = {{CNT_W{bus.wave_rd_data[WIDTH-1]}},
             bus.wave_rd_data};
  end

  // acc * volume * n; n == 0 makes this 0 on its own
  always_comb begin
    logic signed [PW-1:0] pa;
    logic signed [PW-1:0] pv;
    logic signed [PW-1:0] pn;
    pa   = {{(PW-ACC_W){acc[ACC_W-1]}}, acc};
    pv   = {{(PW-32){vol_q[31]}}, vol_q};
    pn   = {{(PW-CNT_W){1'b0}}, n_q};
    prod = pa * pv * pn;
    mag  = prod[PW-1] ? -prod : prod;
  end

  assign divisor   = {1'b0, n_q} + DW'(2);
  assign div_start = (state == MUL);

  seq_divider #(
    .PW(PW),
    .DW(DW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (mag),
    .divisor  (divisor),
    .done     (div_done),
    .quotient (quo)
  );

  // Signed quotient truncates toward zero; then drop the volume fraction
  always_comb begin
    q = neg_q ? -$signed(quo) : $signed(quo);
    if (n_q == '0)
      q = '0;
    mixed = WIDTH'(saturate(
      $signed({{(128-PW){q[PW-1]}}, q}) >>> VOL_FRAC,
      WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      en_q    <= '0;
      vol_q   <= '0;
      n_q     <= '0;
      acc     <= '0;
      addr    <= '0;
      rd_idx  <= '0;
      rd_pend <= 1'b0;
      neg_q   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // busy also covers the out_valid cycle spent in IDLE
      ovr_q   <= bus.sample_tick && busy_q;
      unique case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.sample_tick && !busy_q) begin
            en_q    <= bus.enable;
            vol_q   <= bus.master_volume;
            n_q     <= CNT_W'(popcount(64'(bus.enable)));
            acc     <= '0;
            addr    <= '0;
            rd_pend <= 1'b0;
            busy_q  <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          acc     <= acc + smp;
          rd_idx  <= addr;
          rd_pend <= 1'b1;
          if (addr == IDX_W'(N_WAVEGENS - 1)) begin
            addr  <= '0;
            state <= DRAIN;
          end else begin
            addr  <= addr + IDX_W'(1);
          end
        end
        DRAIN: begin
          acc     <= acc + smp;
          rd_pend <= 1'b0;
          state   <= MUL;
        end
        MUL: begin
          neg_q <= prod[PW-1];
          state <= DIV;
        end
        DIV: begin
          if (div_done)
            state <= OUT;
        end
        OUT: begin
          out_q   <= mixed;
          valid_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_sequencer.sv
// Randomised and directed bench for mix_sequencer.
// Reference model computes the mix from plain arithmetic over the slots.
module tb_mix_sequencer;

  import mixer_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mix_sequencer_if #(
    .WIDTH(WIDTH),
    .N_WAVEGENS(N_WAVEGENS)
  ) bus ();

  mix_sequencer #(
    .WIDTH(WIDTH),
    .N_WAVEGENS(N_WAVEGENS),
    .VOL_FRAC(VOL_FRAC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int slots [N_WAVEGENS];
  int n_chk;
  int n_pass;

  // Registered sample buffer: one-cycle read latency
  always_ff @(posedge clk)
    bus.wave_rd_data <= WIDTH'(slots[bus.wave_rd_addr]);

  task automatic check(
    input string  tag,
    input longint got,
    input longint exp
  );
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
  endtask

  function automatic longint model(
    input logic [N_WAVEGENS-1:0] en,
    input int                    vol
  );
    logic signed [127:0] acc;
    logic signed [127:0] p;
    logic signed [127:0] qq;
    logic signed [127:0] lim;
    int n;
    acc = 0;
    n   = 0;
    for (int i = 0; i < N_WAVEGENS; i++)
      if (en[i]) begin
        acc += slots[i];
        n++;
      end
    if (n == 0)
      return 0;
    p   = acc * vol * n;
    qq  = p / (n + 2);
    qq  = qq >>> VOL_FRAC;
    lim = 128'sd1 <<< (WIDTH - 1);
    if (qq > lim - 1)
      qq = lim - 1;
    if (qq < -lim)
      qq = -lim;
    return longint'(qq);
  endfunction

  task automatic fill(input int v);
    for (int i = 0; i < N_WAVEGENS; i++)
      slots[i] = v;
  endtask

  task automatic run_frame(
    input string                 tag,
    input logic [N_WAVEGENS-1:0] en,
    input int                    vol,
    input int                    extra_at,
    input longint                exp
  );
    int k;
    int busy_lo;
    int ovr;
    int ovr_at;
    bit got;
    @(negedge clk);
    bus.enable        = en;
    bus.master_volume = vol;
    bus.sample_tick   = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_tick   = 1'b0;
    bus.enable        = N_WAVEGENS'($urandom);
    bus.master_volume = $urandom;
    check({tag, "_busy0"}, longint'(bus.busy), 1);
    k = 0; busy_lo = 0; ovr = 0; ovr_at = -1; got = 0;
    while (!got && k < 200) begin
      if (k + 1 == extra_at)
        bus.sample_tick = 1'b1;
      @(posedge clk);
      #1;
      k++;
      bus.sample_tick = 1'b0;
      if (bus.overrun) begin
        ovr++;
        ovr_at = k;
      end
      if (!bus.busy)
        busy_lo++;
      if (bus.out_valid)
        got = 1;
    end
    check({tag, "_lat"}, k, LATENCY);
    check({tag, "_out"}, longint'(bus.out), exp);
    check({tag, "_busy"}, busy_lo, 0);
    if (extra_at > 0) begin
      check({tag, "_ovr_n"}, ovr, 1);
      check({tag, "_ovr_at"}, ovr_at, extra_at);
    end else begin
      check({tag, "_ovr_n"}, ovr, 0);
    end
    @(posedge clk);
    #1;
    check({tag, "_post"},
          longint'({bus.busy, bus.out_valid,
                    bus.wave_rd_addr}), 0);
  endtask

  initial begin
    int k;
    int vcnt;
    logic [N_WAVEGENS-1:0] en;
    int vol;
    n_chk  = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.sample_tick   = 1'b0;
    bus.enable        = '0;
    bus.master_volume = '0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", longint'(bus.out), 0);
    check("rst_flags",
          longint'({bus.out_valid, bus.busy,
                    bus.overrun}), 0);
    check("rst_addr", longint'(bus.wave_rd_addr), 0);
    @(negedge clk);
    rst = 1'b0;

    fill(1000);
    run_frame("all1000", '1, 256, -1, 14222);

    fill(5000);
    slots[3] = -9000;
    run_frame("slot3", 16'h0008, 256, -1, -3000);

    run_frame("none", '0, 256, -1, 0);

    fill(8388607);
    run_frame("satp", '1, 512, -1, 8388607);
    fill(-8388608);
    run_frame("satn", '1, 512, -1, -8388608);

    fill(1000);
    run_frame("ovr", '1, 256, 10, 14222);
    repeat (3) @(negedge clk);
    run_frame("after_ovr", '1, 256, -1, 14222);

    // Reset while the divider is running
    @(negedge clk);
    bus.enable        = '1;
    bus.master_volume = 256;
    bus.sample_tick   = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_tick = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rstdiv_out", longint'(bus.out), 0);
    check("rstdiv_busy", longint'(bus.busy), 0);
    @(negedge clk);
    rst  = 1'b0;
    vcnt = 0;
    for (k = 0; k < 120; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid)
        vcnt++;
    end
    check("rstdiv_novalid", vcnt, 0);
    run_frame("rst_again", '1, 256, -1, 14222);

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N_WAVEGENS; i++)
        slots[i] = int'($urandom_range(0, 32'hFFFFFF))
                   - 8388608;
      en = N_WAVEGENS'($urandom);
      if (t == 0)
        en = '1;
      case ($urandom_range(0, 2))
        0: vol = int'($urandom_range(0, 2048)) - 1024;
        1: vol = int'($urandom_range(0, 64));
        default: vol = int'($urandom);
      endcase
      run_frame($sformatf("rnd%0d", t), en, vol, -1,
                model(en, vol));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
